// File: rtl/ucy_7490.sv
// ucy_7490: clocked, pin-compatible model of the UCY7490 decade counter.
// QA is the /2 section (clocked by CKA falls), {QD,QC,QB} the /5 section
// (clocked by CKB falls). Falling pin edges are detected against the system
// clock, registered once, then applied to the counter state, which drives
// the Q pins directly.
module ucy_7490 #(
    parameter int SYNC_STAGES = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic p1,
    input  logic p2,
    input  logic p3,
    input  logic p4,
    input  logic p5,
    input  logic p6,
    input  logic p7,
    output logic p8,
    output logic p9,
    input  logic p10,
    output logic p11,
    output logic p12,
    input  logic p13,
    input  logic p14
);

    // Power and no-connect pins have no function in the model.
    logic unused_pins;
    assign unused_pins = ^{p4, p5, p10, p13};

    // Pin bundle: {CKA, R9(2), R9(1), R0(2), R0(1), CKB}
    logic [5:0] pins_raw;
    logic [5:0] pins_p0;
    assign pins_raw = {p14, p7, p6, p3, p2, p1};

    generate
        if (SYNC_STAGES > 0) begin : g_sync
            logic [5:0] sync_q [SYNC_STAGES];

            // Synchroniser chain for all functional input pins.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < SYNC_STAGES; i++) begin
                        sync_q[i] <= '0;
                    end
                end else begin
                    sync_q[0] <= pins_raw;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        sync_q[i] <= sync_q[i-1];
                    end
                end
            end

            assign pins_p0 = sync_q[SYNC_STAGES-1];
        end else begin : g_nosync
            assign pins_p0 = pins_raw;
        end
    endgenerate

    // ---- stage p0: pin levels in the clk domain, edge detect ----
    logic ckb_p0, cka_p0;
    logic r0_p0, r9_p0;
    logic hist_a_p1, hist_b_p1;
    logic fall_a_p0, fall_b_p0;

    assign ckb_p0    = pins_p0[0];
    assign r0_p0     = pins_p0[1] & pins_p0[2];
    assign r9_p0     = pins_p0[3] & pins_p0[4];
    assign cka_p0    = pins_p0[5];
    assign fall_a_p0 = hist_a_p1 & ~cka_p0;
    assign fall_b_p0 = hist_b_p1 & ~ckb_p0;

    // ---- stage p1: edge history and registered, reset-qualified falls ----
    logic fall_a_p1, fall_b_p1;

    // History always follows the pins; an edge seen while R0/R9 is active is dropped here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_a_p1 <= 1'b0;
            hist_b_p1 <= 1'b0;
            fall_a_p1 <= 1'b0;
            fall_b_p1 <= 1'b0;
        end else begin
            hist_a_p1 <= cka_p0;
            hist_b_p1 <= ckb_p0;
            fall_a_p1 <= fall_a_p0 & ~r0_p0 & ~r9_p0;
            fall_b_p1 <= fall_b_p0 & ~r0_p0 & ~r9_p0;
        end
    end

    // /5 section successor; codes 5..7 recover to 0.
    function automatic logic [2:0] next_quinary(input logic [2:0] cur);
        logic [2:0] nxt;
        if (cur >= 3'd4) nxt = 3'd0;
        else             nxt = cur + 3'd1;
        return nxt;
    endfunction

    // ---- stage p2: counter state, drives the Q pins ----
    logic       qa_p2;
    logic [2:0] qs_p2;

    // R9 beats R0, which beats counting; the two sections advance independently.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            qa_p2 <= 1'b0;
            qs_p2 <= 3'd0;
        end else if (r9_p0) begin
            qa_p2 <= 1'b1;
            qs_p2 <= 3'd4;
        end else if (r0_p0) begin
            qa_p2 <= 1'b0;
            qs_p2 <= 3'd0;
        end else begin
            if (fall_a_p1) qa_p2 <= ~qa_p2;
            if (fall_b_p1) qs_p2 <= next_quinary(qs_p2);
        end
    end

    assign p12 = qa_p2;
    assign p9  = qs_p2[0];
    assign p8  = qs_p2[1];
    assign p11 = qs_p2[2];

endmodule
